// File: rtl/uart_cmd_decoder_pkg.sv
// rtl/uart_cmd_decoder_pkg.sv - command codes, region bit and state types for the UART debug decoder
package uart_cmd_decoder_pkg;

  localparam logic [7:0] HALT_CMD  = 8'h48;
  localparam logic [7:0] RESET_CMD = 8'h52;
  localparam logic [7:0] START_CMD = 8'h53;
  localparam logic [7:0] WRITE_CMD = 8'h57;
  localparam logic [7:0] READ_CMD  = 8'h72;

  localparam int REGION_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RSEND = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SH_HOLD = 2'd0,
    SH_IN   = 2'd1,
    SH_OUT  = 2'd2,
    SH_LOAD = 2'd3
  } sh_op_e;

endpackage

// File: rtl/uart_cmd_shreg.sv
// rtl/uart_cmd_shreg.sv - MSB-first byte<->word shift register with byte counter
module uart_cmd_shreg
  import uart_cmd_decoder_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  sh_op_e      i_op,
  input  logic        i_clr,
  input  logic [2:0]  i_nbytes,
  input  logic [7:0]  i_byte,
  input  logic [31:0] i_word,
  output logic [31:0] o_word,
  output logic        o_last
);

  logic [31:0] data_q, data_d;
  logic [1:0]  cnt_q, cnt_d;

  // o_last flags that the byte being shifted now completes the word
  assign o_last = ({1'b0, cnt_q} == (i_nbytes - 3'd1));
  assign o_word = data_q;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    case (i_op)
      SH_IN: begin
        data_d = {data_q[23:0], i_byte};
        cnt_d  = o_last ? 2'd0 : cnt_q + 2'd1;
      end
      SH_OUT: begin
        data_d = {data_q[23:0], 8'h00};
        cnt_d  = o_last ? 2'd0 : cnt_q + 2'd1;
      end
      SH_LOAD: begin
        data_d = i_word;
        cnt_d  = 2'd0;
      end
      default: ;
    endcase
    if (i_clr) cnt_d = 2'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_q <= 32'h0;
      cnt_q  <= 2'd0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - decodes host debug bytes into core control, PMEM/DMEM cycles and response bytes
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int PMEM_AW = 10,
  parameter int PMEM_DW = 16,
  parameter int DMEM_AW = 10,
  parameter int DMEM_DW = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_core_run,
  output logic               o_core_rst,
  output logic               o_pmem_we,
  output logic               o_pmem_re,
  output logic [PMEM_AW-1:0] o_pmem_addr,
  output logic [PMEM_DW-1:0] o_pmem_wdata,
  input  logic [PMEM_DW-1:0] i_pmem_rdata,
  output logic               o_dmem_we,
  output logic               o_dmem_re,
  output logic [DMEM_AW-1:0] o_dmem_addr,
  output logic [DMEM_DW-1:0] o_dmem_wdata,
  input  logic [DMEM_DW-1:0] i_dmem_rdata,
  output logic               o_busy,
  output logic               o_rx_drop
);

  localparam logic [2:0]  PMEM_BYTES = 3'(PMEM_DW / 8);
  localparam logic [2:0]  DMEM_BYTES = 3'(DMEM_DW / 8);
  localparam logic [15:0] PMEM_MASK  = 16'((32'd1 << PMEM_AW) - 32'd1);
  localparam logic [15:0] DMEM_MASK  = 16'((32'd1 << DMEM_AW) - 32'd1);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d, rem_q, rem_d;
  logic        region_q, region_d, is_wr_q, is_wr_d;
  logic        run_q, run_d, rst_q, rst_d, drop_q, drop_d, we_q, we_d;

  sh_op_e      sh_op;
  logic        sh_clr, sh_last;
  logic [2:0]  sh_nbytes;
  logic [31:0] sh_word, sh_load_word, hdr_word;
  logic [15:0] addr_inc;

  assign addr_inc  = (addr_q + 16'd1) & (region_q ? PMEM_MASK : DMEM_MASK);
  assign hdr_word  = {sh_word[23:0], i_rx_data};
  assign sh_nbytes = (state_q == ST_HDR) ? 3'd4 : (region_q ? PMEM_BYTES : DMEM_BYTES);
  // read words are left-justified so the first byte out is always bits 31:24
  assign sh_load_word = region_q ? (32'(i_pmem_rdata) << (32 - PMEM_DW))
                                 : (32'(i_dmem_rdata) << (32 - DMEM_DW));

  uart_cmd_shreg u_shreg (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_op     (sh_op),
    .i_clr    (sh_clr),
    .i_nbytes (sh_nbytes),
    .i_byte   (i_rx_data),
    .i_word   (sh_load_word),
    .o_word   (sh_word),
    .o_last   (sh_last)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    region_d = region_q;
    is_wr_d  = is_wr_q;
    run_d    = run_q;
    rst_d    = 1'b0;
    drop_d   = 1'b0;
    we_d     = 1'b0;
    sh_op    = SH_HOLD;
    sh_clr   = 1'b0;

    // Address/count bookkeeping happens in the cycle the write strobe is out
    if (we_q) begin
      addr_d = addr_inc;
      rem_d  = rem_q - 16'd1;
      if (rem_q == 16'd1) state_d = ST_IDLE;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            HALT_CMD:  run_d = 1'b0;
            START_CMD: run_d = 1'b1;
            RESET_CMD: rst_d = 1'b1;
            WRITE_CMD, READ_CMD: begin
              state_d = ST_HDR;
              is_wr_d = (i_rx_data == WRITE_CMD);
              sh_clr  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_HDR: begin
        if (i_rx_valid) begin
          sh_op = SH_IN;
          if (sh_last) begin
            region_d = hdr_word[16+REGION_BIT];
            addr_d   = hdr_word[31:16] & (region_d ? PMEM_MASK : DMEM_MASK);
            rem_d    = hdr_word[15:0];
            if (hdr_word[15:0] == 16'd0) state_d = ST_IDLE;
            else                         state_d = is_wr_q ? ST_WDATA : ST_RREQ;
          end
        end
      end
      ST_WDATA: begin
        if (i_rx_valid) begin
          sh_op = SH_IN;
          we_d  = sh_last;
        end
      end
      ST_RREQ:  state_d = ST_RWAIT;
      ST_RWAIT: begin
        sh_op   = SH_LOAD;
        state_d = ST_RSEND;
      end
      ST_RSEND: begin
        if (i_tx_ready) begin
          sh_op = SH_OUT;
          if (sh_last) begin
            addr_d  = addr_inc;
            rem_d   = rem_q - 16'd1;
            state_d = (rem_q == 16'd1) ? ST_IDLE : ST_RREQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_rx_valid && (state_q == ST_RREQ || state_q == ST_RWAIT || state_q == ST_RSEND))
      drop_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 16'd0;
      rem_q    <= 16'd0;
      region_q <= 1'b0;
      is_wr_q  <= 1'b0;
      run_q    <= 1'b0;
      rst_q    <= 1'b0;
      drop_q   <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      region_q <= region_d;
      is_wr_q  <= is_wr_d;
      run_q    <= run_d;
      rst_q    <= rst_d;
      drop_q   <= drop_d;
      we_q     <= we_d;
    end
  end

  assign o_core_run   = run_q;
  assign o_core_rst   = rst_q;
  assign o_rx_drop    = drop_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_tx_valid   = (state_q == ST_RSEND);
  assign o_tx_data    = sh_word[31:24];
  assign o_pmem_we    = we_q & region_q;
  assign o_dmem_we    = we_q & ~region_q;
  assign o_pmem_re    = (state_q == ST_RREQ) & region_q;
  assign o_dmem_re    = (state_q == ST_RREQ) & ~region_q;
  assign o_pmem_addr  = addr_q[PMEM_AW-1:0];
  assign o_dmem_addr  = addr_q[DMEM_AW-1:0];
  assign o_pmem_wdata = sh_word[PMEM_DW-1:0];
  assign o_dmem_wdata = sh_word[DMEM_DW-1:0];

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - self-checking bench: control-command table, directed transfers, random traffic vs host-level model
module tb_uart_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        tx_ready;
  logic        o_core_run, o_core_rst;
  logic        o_pmem_we, o_pmem_re, o_dmem_we, o_dmem_re;
  logic [9:0]  o_pmem_addr, o_dmem_addr;
  logic [15:0] o_pmem_wdata, pmem_rdata;
  logic [31:0] o_dmem_wdata, dmem_rdata;
  logic        o_busy, o_rx_drop;

  always #5 clk = ~clk;

  uart_cmd_decoder dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(tx_ready),
    .o_core_run(o_core_run), .o_core_rst(o_core_rst),
    .o_pmem_we(o_pmem_we), .o_pmem_re(o_pmem_re), .o_pmem_addr(o_pmem_addr),
    .o_pmem_wdata(o_pmem_wdata), .i_pmem_rdata(pmem_rdata),
    .o_dmem_we(o_dmem_we), .o_dmem_re(o_dmem_re), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_rdata(dmem_rdata),
    .o_busy(o_busy), .o_rx_drop(o_rx_drop)
  );

  typedef struct {
    bit          pm;
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] rx;
    logic       exp_run;
    logic       exp_rst;
  } ctl_vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Environment memories (driven by the DUT) and the host's own view of them
  bit [15:0] pmem_env [1024];
  bit [31:0] dmem_env [1024];
  bit [15:0] pmem_mdl [1024];
  bit [31:0] dmem_mdl [1024];

  wr_t        wr_obs[$];
  logic [7:0] tx_obs[$];
  logic [31:0] wq[$];
  int  rst_cnt = 0, drop_cnt = 0;
  int  rdy_mode = 0, stall_cnt = 0;
  bit  chk_stable = 1'b0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] outs();
    return 96'({o_tx_data, o_tx_valid, o_core_run, o_core_rst, o_pmem_we, o_pmem_re,
                o_pmem_addr, o_pmem_wdata, o_dmem_we, o_dmem_re, o_dmem_addr,
                o_dmem_wdata, o_busy, o_rx_drop});
  endfunction

  always @(posedge clk) begin
    if (o_pmem_re) pmem_rdata <= pmem_env[o_pmem_addr];
    if (o_pmem_we) pmem_env[o_pmem_addr] <= o_pmem_wdata;
    if (o_dmem_re) dmem_rdata <= dmem_env[o_dmem_addr];
    if (o_dmem_we) dmem_env[o_dmem_addr] <= o_dmem_wdata;
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) tx_ready = 1'b1;
    else if (rdy_mode == 1) tx_ready = 1'($urandom_range(0, 1));
    else begin
      stall_cnt = (stall_cnt == 5) ? 0 : stall_cnt + 1;
      tx_ready  = (stall_cnt == 5);
    end
  end

  always @(negedge clk) begin
    if (o_pmem_we) wr_obs.push_back('{1'b1, int'(o_pmem_addr), 32'(o_pmem_wdata)});
    if (o_dmem_we) wr_obs.push_back('{1'b0, int'(o_dmem_addr), o_dmem_wdata});
    if (o_tx_valid && tx_ready) tx_obs.push_back(o_tx_data);
    if (o_core_rst) rst_cnt++;
    if (o_rx_drop) drop_cnt++;
    if (chk_stable && pv && !pr) chk("tx_hold", 96'({o_tx_valid, o_tx_data}), 96'({1'b1, pd}));
    pv = o_tx_valid;
    pr = tx_ready;
    pd = o_tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      if (!o_busy) break;
      tick();
    end
    if (o_busy) chk("idle_timeout", 96'(o_busy), 96'(0));
    repeat (2) tick();
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input bit pm, input int addr, input int n, input int last_gap);
    logic [15:0] hw;
    hw = 16'((pm ? 1024 : 0) + addr);
    send_byte(cmd, 1);
    send_byte(hw[15:8], 1);
    send_byte(hw[7:0], 1);
    send_byte(8'(n >> 8), 1);
    send_byte(8'(n), last_gap);
  endtask

  task automatic host_write(input bit pm, input int addr, input int n);
    wr_t exp[$];
    int a;
    logic [31:0] d;
    wr_obs.delete();
    tx_obs.delete();
    send_hdr(8'h57, pm, addr, n, 1);
    for (int i = 0; i < n; i++) begin
      a = (addr + i) % 1024;
      d = pm ? {16'h0, wq[i][15:0]} : wq[i];
      exp.push_back('{pm, a, d});
      if (pm) pmem_mdl[a] = d[15:0];
      else    dmem_mdl[a] = d;
      if (!pm) begin
        send_byte(d[31:24], $urandom_range(1, 3));
        send_byte(d[23:16], $urandom_range(1, 3));
      end
      send_byte(d[15:8], $urandom_range(1, 3));
      send_byte(d[7:0], $urandom_range(1, 3));
    end
    wait_idle();
    chk("wr_count", 96'(wr_obs.size()), 96'(exp.size()));
    for (int i = 0; i < exp.size() && i < wr_obs.size(); i++) begin
      chk("wr_region", 96'(wr_obs[i].pm), 96'(exp[i].pm));
      chk("wr_addr", 96'(wr_obs[i].addr), 96'(exp[i].addr));
      chk("wr_data", 96'(wr_obs[i].data), 96'(exp[i].data));
    end
    chk("wr_no_tx", 96'(tx_obs.size()), 96'(0));
  endtask

  task automatic host_read(input bit pm, input int addr, input int n, input bit lat, input bit inject);
    logic [7:0] exp[$];
    int a, d0;
    logic run0;
    for (int i = 0; i < n; i++) begin
      a = (addr + i) % 1024;
      if (pm) begin
        exp.push_back(pmem_mdl[a][15:8]);
        exp.push_back(pmem_mdl[a][7:0]);
      end else begin
        exp.push_back(dmem_mdl[a][31:24]);
        exp.push_back(dmem_mdl[a][23:16]);
        exp.push_back(dmem_mdl[a][15:8]);
        exp.push_back(dmem_mdl[a][7:0]);
      end
    end
    wr_obs.delete();
    tx_obs.delete();
    d0   = drop_cnt;
    run0 = o_core_run;
    send_hdr(8'h72, pm, addr, n, lat ? 0 : 1);
    if (lat) begin
      chk("lat_c1", 96'(o_tx_valid), 96'(0));
      tick();
      chk("lat_c2", 96'(o_tx_valid), 96'(0));
      tick();
      chk("lat_c3", 96'(o_tx_valid), 96'(1));
    end
    if (inject) begin
      repeat (2) tick();
      send_byte(8'h48, 1);
    end
    wait_idle();
    chk("rd_count", 96'(tx_obs.size()), 96'(exp.size()));
    for (int i = 0; i < exp.size() && i < tx_obs.size(); i++)
      chk("rd_byte", 96'(tx_obs[i]), 96'(exp[i]));
    chk("rd_no_wr", 96'(wr_obs.size()), 96'(0));
    if (inject) begin
      chk("drop_pulse", 96'(drop_cnt - d0), 96'(1));
      chk("drop_run", 96'(o_core_run), 96'(run0));
    end
  endtask

  ctl_vec_t tbl[8];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pm, op, addr, n, r0;

    tbl = '{'{8'h53, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b0}, '{8'h48, 1'b0, 1'b0},
            '{8'h00, 1'b0, 1'b0}, '{8'h53, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b0},
            '{8'h52, 1'b1, 1'b1}, '{8'hA5, 1'b1, 1'b0}};

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) tick();
    chk("reset_outs", outs(), 96'(0));
    rst = 1'b0;
    tick();

    // Control commands act one cycle after their strobe; reset is a single-cycle pulse
    r0 = rst_cnt;
    for (int i = 0; i < 8; i++) begin
      send_byte(tbl[i].rx, 0);
      chk("ctl_run", 96'(o_core_run), 96'(tbl[i].exp_run));
      chk("ctl_rst", 96'(o_core_rst), 96'(tbl[i].exp_rst));
      chk("ctl_busy", 96'(o_busy), 96'(0));
      tick();
      chk("ctl_rst_off", 96'(o_core_rst), 96'(0));
    end
    chk("ctl_rst_count", 96'(rst_cnt - r0), 96'(1));
    chk("ctl_no_drop", 96'(drop_cnt), 96'(0));

    wq = '{32'h0000, 32'hFFFF};
    host_write(1'b1, 0, 2);

    wq = '{32'h0000000B, 32'h0000000C};
    host_write(1'b0, 1, 2);
    host_read(1'b0, 1, 2, 1'b1, 1'b0);

    wq = '{32'hDEADBEEF};
    host_write(1'b0, 5, 1);
    rdy_mode = 2;
    chk_stable = 1'b1;
    host_read(1'b0, 5, 1, 1'b0, 1'b1);
    chk_stable = 1'b0;
    rdy_mode = 0;
    chk("stall_idle", 96'(o_busy), 96'(0));

    wq = '{32'h1234, 32'hABCD};
    host_write(1'b1, 1023, 2);
    host_read(1'b1, 1023, 2, 1'b1, 1'b0);
    host_write(1'b1, 7, 0);
    host_read(1'b0, 7, 0, 1'b0, 1'b0);

    // Reset three bytes into a DMEM word, with a START byte colliding with reset
    wq = '{32'h11223344};
    host_write(1'b0, 9, 1);
    wr_obs.delete();
    send_hdr(8'h57, 1'b0, 9, 1, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 1);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h53;
    tick();
    rx_valid = 1'b0;
    chk("midrst_outs", outs(), 96'(0));
    rst = 1'b0;
    repeat (2) tick();
    chk("midrst_run", 96'(o_core_run), 96'(0));
    chk("midrst_nowr", 96'(wr_obs.size()), 96'(0));
    host_read(1'b0, 9, 1, 1'b0, 1'b0);

    rdy_mode = 1;
    for (int t = 0; t < 24; t++) begin
      pm   = $urandom_range(0, 1);
      op   = $urandom_range(0, 2);
      addr = ($urandom_range(0, 3) == 0) ? 1024 - $urandom_range(1, 3) : $urandom_range(0, 1023);
      n    = $urandom_range(0, 4);
      if (op < 2) begin
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
        host_write(pm[0], addr, n);
      end else begin
        host_read(pm[0], addr, n, 1'b0, 1'b0);
      end
    end
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
